hazard_fwd_ctrl: RTL

Next-generation pipeline hazard controller for the 5-stage core. It merges the operand forwarding selects (EX→EX, MEM→EX, MEM→MEM) with a sequential load-use stall controller. The stall length is parametrised, the controller freezes the whole pipeline while memory is busy, and branch flushes take priority over stalls. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the PC and IF/ID enables, the ID/EX bubble and the EX-stage operand muxes.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 6 +
 rtl/hazard_fwd_ctrl_if.sv | 23 ++
 rtl/hazard_fwd_ctrl_fwd_sel.sv | 14 +
 rtl/hazard_fwd_ctrl.sv | 64 ++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_pkg: shared forwarding-select encodings, stall FSM states and default widths
package hazard_pkg;
  localparam int REG_AW_DEF = 4;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01} fwd_sel_t;
  typedef enum logic {IDLE, STALL} state_t;
endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: pipeline-register taps in, forwarding selects and stall controls out
//   master: the pipeline (drives ID/EX/MEM/WB fields, mem_busy, flush)
//   slave:  the hazard controller (drives fwd_a/fwd_b/fwd_mem, stalls, freeze, stall_cnt)
interface hazard_fwd_ctrl_if import hazard_pkg::*; #(parameter int REG_AW = REG_AW_DEF, parameter int CNT_W = 16) ();
  logic [REG_AW-1:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic if_id_rs_used, if_id_rt_used, if_id_is_store, id_ex_memread;
  logic ex_mem_regwrite, ex_mem_memwrite, mem_wb_regwrite, mem_busy, flush;
  fwd_sel_t fwd_a, fwd_b;
  logic fwd_mem, stall_pc, stall_if_id, bubble_id_ex, freeze;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output if_id_rs, if_id_rt, if_id_rs_used, if_id_rt_used, if_id_is_store,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, ex_mem_memwrite, mem_wb_rd, mem_wb_regwrite, mem_busy, flush,
    input  fwd_a, fwd_b, fwd_mem, stall_pc, stall_if_id, bubble_id_ex, freeze, stall_cnt
  );
  modport slave (
    input  if_id_rs, if_id_rt, if_id_rs_used, if_id_rt_used, if_id_is_store,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, ex_mem_memwrite, mem_wb_rd, mem_wb_regwrite, mem_busy, flush,
    output fwd_a, fwd_b, fwd_mem, stall_pc, stall_if_id, bubble_id_ex, freeze, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// fwd_sel: per-operand forwarding priority selector, EX/MEM over MEM/WB, register 0 never forwarded
//   src: EX source address; ex_mem_*/mem_wb_*: producer taps; sel: operand mux select
module fwd_sel import hazard_pkg::*; #(parameter int REG_AW = REG_AW_DEF) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              ex_mem_regwrite,
  input  logic              mem_wb_regwrite,
  output fwd_sel_t          sel
);
  always_comb
    sel = (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == src) ? FWD_EXMEM :
          (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == src) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding selects plus multi-cycle load-use stall FSM with freeze and flush
//   clk, rst_n (async active-low); bus: hazard_fwd_ctrl_if.slave
//   optional HAZARD_PERF_CNT_EN: saturating stall_cnt of stall/freeze cycles, else tied to 0
module hazard_fwd_ctrl import hazard_pkg::*; #(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LU_STALL_CYC = 1,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_fwd_ctrl_if.slave bus
);
  localparam logic [3:0] LU_M1 = 4'(LU_STALL_CYC - 1);
  state_t state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic hz, stall;
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (.src(bus.id_ex_rs), .ex_mem_rd(bus.ex_mem_rd), .mem_wb_rd(bus.mem_wb_rd),
    .ex_mem_regwrite(bus.ex_mem_regwrite), .mem_wb_regwrite(bus.mem_wb_regwrite), .sel(bus.fwd_a));
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (.src(bus.id_ex_rt), .ex_mem_rd(bus.ex_mem_rd), .mem_wb_rd(bus.mem_wb_rd),
    .ex_mem_regwrite(bus.ex_mem_regwrite), .mem_wb_regwrite(bus.mem_wb_regwrite), .sel(bus.fwd_b));
  assign bus.fwd_mem = bus.ex_mem_memwrite && bus.mem_wb_regwrite && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.ex_mem_rd;
  // store data (rt) of a store is covered by MEM->MEM forwarding, so only its address operand stalls
  assign hz = bus.id_ex_memread && bus.id_ex_rd != '0 &&
              ((bus.if_id_rs_used && bus.if_id_rs == bus.id_ex_rd) ||
               (bus.if_id_rt_used && bus.if_id_rt == bus.id_ex_rd && !bus.if_id_is_store));
  always_comb begin
    stall = rst_n && !bus.mem_busy && !bus.flush && (state == STALL || hz);
    state_nxt = state;
    rem_nxt = rem;
    if (!bus.mem_busy) begin
      if (bus.flush) begin
        state_nxt = IDLE;
        rem_nxt = '0;
      end else if (state == STALL) begin
        rem_nxt = rem - 4'd1;
        state_nxt = (rem == 4'd1) ? IDLE : STALL;
      end else if (hz && LU_STALL_CYC > 1) begin
        state_nxt = STALL;
        rem_nxt = LU_M1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
    end else begin
      state <= state_nxt;
      rem <= rem_nxt;
    end
  assign bus.stall_pc = stall;
  assign bus.stall_if_id = stall;
  assign bus.bubble_id_ex = stall;
  assign bus.freeze = bus.mem_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if ((stall || bus.mem_busy) && !(&cnt)) cnt <= cnt + 1'b1;
  assign bus.stall_cnt = cnt;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule
